// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: lock-state type, requester limit and pointer-advance helper
// shared by fifo_wr_arbiter and its round-robin picker.
package fifo_arb_pkg;

  localparam int MAX_REQ = 16;
  localparam int PTR_W   = $clog2(MAX_REQ);

  typedef enum logic [0:0] {
    ARB_UNLOCKED = 1'b0,
    ARB_LOCKED   = 1'b1
  } arb_state_e;

  // Next round-robin pointer; wraps explicitly so non-power-of-two counts work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx,
                                                input logic [PTR_W:0]   n_req);
    logic [PTR_W-1:0] nxt;
    if ({1'b0, idx} == (n_req - (PTR_W+1)'(1))) begin
      nxt = {PTR_W{1'b0}};
    end else begin
      nxt = idx + PTR_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker. Grants the first masked request
// found scanning from ptr upward, wrapping at N.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic [N-1:0] mask,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         grant_any
);

  logic [N-1:0] eff_s;
  logic [W:0]   sum_s;
  logic [W-1:0] pos_s;
  logic         hit_s;

  assign eff_s = req & mask;

  // Scan N positions starting at ptr; the first eligible one wins.
  always_comb begin
    grant     = {N{1'b0}};
    grant_idx = {W{1'b0}};
    grant_any = 1'b0;
    sum_s     = {(W+1){1'b0}};
    pos_s     = {W{1'b0}};
    hit_s     = 1'b0;
    for (int k = 0; k < N; k++) begin
      sum_s        = {1'b0, ptr} + (W+1)'(k);
      sum_s        = (sum_s >= (W+1)'(N)) ? (sum_s - (W+1)'(N)) : sum_s;
      pos_s        = W'(sum_s);
      hit_s        = !grant_any && eff_s[pos_s];
      grant[pos_s] = hit_s;
      grant_idx    = hit_s ? pos_s : grant_idx;
      grant_any    = grant_any | hit_s;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin merge of N_REQ valid/ready producers into one
// registered FIFO write port. Define FIFO_ARB_LOCK_EN to keep packets contiguous.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ  = 4,
  parameter  int DATA_W = 8,
  localparam int SRC_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    fifo_full,
  output logic                    fifo_wr_en,
  output logic [DATA_W-1:0]       fifo_wr_data,
  output logic [SRC_W-1:0]        fifo_wr_src
);

  logic              out_v_q, out_v_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SRC_W-1:0]  src_q, src_d;
  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]  mask_s, grant_s;
  logic [SRC_W-1:0]  grant_idx_s, ptr_inc_s;
  logic              grant_any_s, stall_s, accept_s;
  logic [DATA_W-1:0] beat_s [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_beat
    assign beat_s[i] = req_data[i*DATA_W +: DATA_W];
  end

`ifdef FIFO_ARB_LOCK_EN
  arb_state_e       state_q, state_d;
  logic [SRC_W-1:0] owner_q, owner_d;
  logic [SRC_W-1:0] owner_inc_s;

  // While a packet is open only its owner may be granted.
  always_comb begin
    mask_s = {N_REQ{1'b1}};
    if (state_q == ARB_LOCKED) begin
      mask_s          = {N_REQ{1'b0}};
      mask_s[owner_q] = 1'b1;
    end else begin
      mask_s = {N_REQ{1'b1}};
    end
  end

  assign owner_inc_s = SRC_W'(next_ptr(PTR_W'(owner_q), (PTR_W+1)'(N_REQ)));
`else
  logic unused_last_s;
  assign unused_last_s = ^req_last;
  assign mask_s        = {N_REQ{1'b1}};
`endif

  rr_arbiter #(
    .N (N_REQ),
    .W (SRC_W)
  ) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .mask      (mask_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .grant_any (grant_any_s)
  );

  assign stall_s   = out_v_q & fifo_full;
  assign accept_s  = grant_any_s & ~stall_s;
  assign req_ready = grant_s & {N_REQ{~stall_s & rst_n}};
  assign ptr_inc_s = SRC_W'(next_ptr(PTR_W'(grant_idx_s), (PTR_W+1)'(N_REQ)));

  // Output stage holds on stall, reloads on accept, otherwise drains.
  always_comb begin
    out_v_d  = out_v_q;
    data_d   = data_q;
    src_d    = src_q;
    rr_ptr_d = rr_ptr_q;
`ifdef FIFO_ARB_LOCK_EN
    state_d  = state_q;
    owner_d  = owner_q;
`endif
    if (stall_s) begin
      out_v_d = out_v_q;
    end else if (accept_s) begin
      out_v_d = 1'b1;
      data_d  = beat_s[grant_idx_s];
      src_d   = grant_idx_s;
`ifdef FIFO_ARB_LOCK_EN
      case (state_q)
        ARB_UNLOCKED: begin
          rr_ptr_d = ptr_inc_s;
          if (!req_last[grant_idx_s]) begin
            state_d = ARB_LOCKED;
            owner_d = grant_idx_s;
          end else begin
            state_d = ARB_UNLOCKED;
          end
        end
        ARB_LOCKED: begin
          if (req_last[grant_idx_s]) begin
            state_d  = ARB_UNLOCKED;
            rr_ptr_d = owner_inc_s;
          end else begin
            state_d = ARB_LOCKED;
          end
        end
        default: begin
          state_d = ARB_UNLOCKED;
        end
      endcase
`else
      rr_ptr_d = ptr_inc_s;
`endif
    end else begin
      out_v_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v_q  <= 1'b0;
      data_q   <= {DATA_W{1'b0}};
      src_q    <= {SRC_W{1'b0}};
      rr_ptr_q <= {SRC_W{1'b0}};
`ifdef FIFO_ARB_LOCK_EN
      state_q  <= ARB_UNLOCKED;
      owner_q  <= {SRC_W{1'b0}};
`endif
    end else begin
      out_v_q  <= out_v_d;
      data_q   <= data_d;
      src_q    <= src_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef FIFO_ARB_LOCK_EN
      state_q  <= state_d;
      owner_q  <= owner_d;
`endif
    end
  end

  assign fifo_wr_en   = out_v_q;
  assign fifo_wr_data = data_q;
  assign fifo_wr_src  = src_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed stimulus with a write scoreboard; a negedge
// monitor pops the expected (data, src) for every FIFO write it observes.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic [1:0]  fifo_wr_src;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] src;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  fifo_wr_arbiter #(.N_REQ(4), .DATA_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wr_src  (fifo_wr_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_wr(input logic [7:0] d, input logic [1:0] s);
    exp_t e;
    e.data = d;
    e.src  = s;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every real FIFO write must match the next expected beat.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (fifo_wr_en === 1'b1 && fifo_full === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("spurious_write", {24'd0, fifo_wr_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("wr_data", {24'd0, fifo_wr_data}, {24'd0, e.data});
          chk("wr_src", {30'd0, fifo_wr_src}, {30'd0, e.src});
        end
      end
    end
  end

  initial begin
    logic hs;
    int   beat;
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    req_last  = 4'h0;
    fifo_full = 1'b0;

    // Reset state, with all requesters already valid.
    #12;
    chk("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    chk("rst_wr_data", {24'd0, fifo_wr_data}, 32'd0);
    chk("rst_wr_src", {30'd0, fifo_wr_src}, 32'd0);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);

    // All four valid: strict rotation 0,1,2,3,0,1.
    for (int i = 0; i < 6; i++) expect_wr(8'h10 + 8'(i % 4), 2'(i % 4));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    req_valid = 4'h0;

    // Only requester 2: five back-to-back beats.
    req_valid      = 4'b0100;
    req_data[23:16] = 8'h20;
    for (int i = 0; i < 5; i++) expect_wr(8'h20 + 8'(i), 2'd2);
    for (int i = 0; i < 5; i++) begin
      step();
      req_data[23:16] = 8'h21 + 8'(i);
    end
    req_valid = 4'h0;

    // Pointer now 3: requester 3 wins first.
    req_valid = 4'hF;
    req_data  = {8'h33, 8'h32, 8'h31, 8'h30};
    expect_wr(8'h33, 2'd3);
    step();
    req_valid = 4'h0;

    // Stall: 0xA5 held through 3 full cycles, then written once, 0x42 accepted same cycle.
    req_valid = 4'b0010;
    req_data  = {8'h43, 8'h42, 8'hA5, 8'h40};
    expect_wr(8'hA5, 2'd1);
    expect_wr(8'h42, 2'd2);
    step();
    req_valid = 4'hF;
    req_data  = {8'h43, 8'h42, 8'h41, 8'h40};
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_wr_en", {31'd0, fifo_wr_en}, 32'd1);
      chk("stall_data", {24'd0, fifo_wr_data}, 32'h0000_00A5);
      chk("stall_src", {30'd0, fifo_wr_src}, 32'd1);
      chk("stall_ready", {28'd0, req_ready}, 32'd0);
    end
    fifo_full = 1'b0;
    step();
    req_valid = 4'h0;

    // Reset while a beat from requester 1 is stalled: beat discarded, pointer back to 0.
    req_valid = 4'b0010;
    req_data  = {8'h53, 8'h52, 8'h55, 8'h50};
    step();
    req_valid = 4'h0;
    fifo_full = 1'b1;
    step();
    step();
    #2;
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_data  = {8'h63, 8'h62, 8'h61, 8'h60};
    #1;
    chk("arst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    chk("arst_data", {24'd0, fifo_wr_data}, 32'd0);
    chk("arst_src", {30'd0, fifo_wr_src}, 32'd0);
    chk("arst_ready", {28'd0, req_ready}, 32'd0);
    @(negedge clk);
    fifo_full = 1'b0;
    rst_n     = 1'b1;
    expect_wr(8'h60, 2'd0);
    step();
    req_valid = 4'h0;

    // Requester 1 sends a 3-beat packet while 0, 2 and 3 stay valid.
`ifdef FIFO_ARB_LOCK_EN
    expect_wr(8'h81, 2'd1);
    expect_wr(8'h82, 2'd1);
    expect_wr(8'h83, 2'd1);
    expect_wr(8'h72, 2'd2);
    expect_wr(8'h73, 2'd3);
    expect_wr(8'h70, 2'd0);
`else
    expect_wr(8'h81, 2'd1);
    expect_wr(8'h72, 2'd2);
    expect_wr(8'h73, 2'd3);
    expect_wr(8'h70, 2'd0);
    expect_wr(8'h82, 2'd1);
    expect_wr(8'h72, 2'd2);
`endif
    req_valid = 4'hF;
    req_data  = {8'h73, 8'h72, 8'h81, 8'h70};
    req_last  = 4'b1101;
    beat      = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      hs = req_valid[1] & req_ready[1];
      step();
      if (hs) begin
        beat++;
        if (beat == 3) begin
          req_valid[1] = 1'b0;
        end else begin
          req_data[15:8] = 8'h81 + 8'(beat);
          req_last[1]    = (beat == 2);
        end
      end
    end
    req_valid = 4'h0;
    req_last  = 4'h0;

    // Drain: output stage empties and every expected write was seen.
    step();
    step();
    chk("drain_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    chk("missing_writes", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
